// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave):
// request/grant, write payload and read response.
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: byte enables, store lane replication, load extraction.
// Define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses instead of force-aligning them.
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] StoreData,
    load_store_unit_if.master     mem,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  misaligned
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    return 4'b0001 << a;
            SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] wdata_of(input logic [1:0] size,
                                                       input logic [DATA_WIDTH-1:0] d);
        case (size)
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Byte offset of the addressed lane after natural alignment of H/W accesses.
    function automatic logic [1:0] offset_of(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_B:    return a;
            SZ_H:    return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] rdata,
                                                      input logic [1:0] off,
                                                      input logic [1:0] size,
                                                      input logic uns);
        logic [DATA_WIDTH-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            SZ_B:    return uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    logic [1:0] state;
    logic [1:0] size_in;
    logic       mis_in;
    logic       is_load_q;
    logic [1:0] size_q;
    logic       uns_q;
    logic [1:0] off_q;
    logic       mis_q;

    always_comb begin
        size_in = SZ_W;
        case (Funct3[1:0])
            2'b00:   size_in = SZ_B;
            2'b01:   size_in = SZ_H;
            default: size_in = SZ_W;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_in = (MemRead | MemWrite) &
                    (((size_in == SZ_H) & ALUResult[0]) |
                     ((size_in == SZ_W) & (ALUResult[1:0] != 2'b00)));
`else
    assign mis_in = 1'b0;
`endif

    // Control outputs decode from registered state only; mem_req drops with async reset.
    assign req_ready   = (state == ST_IDLE);
    assign mem.mem_req = (state == ST_REQ);
    assign rsp_valid   = (state == ST_RESP);
    assign misaligned  = mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            is_load_q     <= 1'b0;
            size_q        <= SZ_B;
            uns_q         <= 1'b0;
            off_q         <= 2'b00;
            mis_q         <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= 4'b0000;
            mem.mem_wdata <= '0;
            rsp_data      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        is_load_q     <= MemRead;
                        size_q        <= size_in;
                        uns_q         <= Funct3[2];
                        off_q         <= offset_of(size_in, ALUResult[1:0]);
                        mis_q         <= mis_in;
                        mem.mem_we    <= MemWrite & ~MemRead;
                        mem.mem_addr  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                        mem.mem_be    <= be_of(size_in, ALUResult[1:0]);
                        mem.mem_wdata <= wdata_of(size_in, StoreData);
                        if (!(MemRead | MemWrite)) begin
                            rsp_data <= ALUResult;
                            state    <= ST_RESP;
                        end else begin
                            rsp_data <= '0;
                            state    <= mis_in ? ST_RESP : ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem.mem_gnt) state <= is_load_q ? ST_WAIT : ST_RESP;
                end
                ST_WAIT: begin
                    if (mem.mem_rvalid) begin
                        rsp_data <= extract(mem.mem_rdata, off_q, size_q, uns_q);
                        state    <= ST_RESP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; follows LSU_MISALIGN_TRAP_EN if defined.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult;
    logic [31:0] StoreData;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        misaligned;
    int          checks = 0;
    int          failures = 0;

    load_store_unit_if #(.DATA_WIDTH(32)) bus ();

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Funct3     (Funct3),
        .ALUResult  (ALUResult),
        .StoreData  (StoreData),
        .mem        (bus.master),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation for a single cycle; afterwards the bench is in cycle 1.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd);
        MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; StoreData = sd;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
        checks++; if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== 69'd0) begin failures++; $display("FAIL reset_mem_bus got=%b/%b/%h/%h exp=0", bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata); end
        checks++; if ({rsp_valid, rsp_data, misaligned} !== 34'd0) begin failures++; $display("FAIL reset_rsp got=%b/%h/%b exp=0", rsp_valid, rsp_data, misaligned); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_store_byte();
        bus.mem_gnt = 1'b0;
        issue(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL sb_mem_req got=%b exp=1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0000_1000) begin failures++; $display("FAIL sb_addr got=%h exp=00001000", bus.mem_addr); end
        checks++; if (bus.mem_be !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", bus.mem_be); end
        checks++; if (bus.mem_wdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", bus.mem_wdata); end
        checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL sb_we got=%b exp=1", bus.mem_we); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL sb_busy_ready got=%b exp=0", req_ready); end
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd0) begin failures++; $display("FAIL sb_rsp got=%b/%h exp=1/00000000", rsp_valid, rsp_data); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL sb_req_drop got=%b exp=0", bus.mem_req); end
        step();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL sb_idle got=%b/%b exp=0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_store_half();
        issue(1'b0, 1'b1, 3'b001, 32'h0000_1006, 32'h1234_BEEF);
        checks++; if (bus.mem_be !== 4'b1100 || bus.mem_wdata !== 32'hBEEF_BEEF || bus.mem_addr !== 32'h0000_1004) begin failures++; $display("FAIL sh_bus got=%b/%h/%h exp=1100/beefbeef/00001004", bus.mem_be, bus.mem_wdata, bus.mem_addr); end
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        step();
    endtask

    task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp_data, input string name);
        issue(1'b1, 1'b0, f3, 32'h0000_2002, 32'h0);
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'b0100 || bus.mem_addr !== 32'h0000_2000) begin failures++; $display("FAIL %s_bus got=%b/%b/%b/%h exp=1/0/0100/00002000", name, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr); end
        // rvalid while still requesting must be ignored
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        step();
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.mem_req !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL %s_rvalid_in_req got=%b/%b exp=1/0", name, bus.mem_req, rsp_valid); end
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12F0_3456;
        step();
        bus.mem_rvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_data) begin failures++; $display("FAIL %s_rsp got=%b/%h exp=1/%h", name, rsp_valid, rsp_data, exp_data); end
        step();
    endtask

    task automatic test_load_half_stall();
        int held;
        held = 0;
        issue(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus.mem_gnt = (i == 3);
            if (bus.mem_req === 1'b1 && bus.mem_be === 4'b1100 && bus.mem_addr === 32'h0000_2000 && bus.mem_we === 1'b0) held++;
            step();
        end
        bus.mem_gnt = 1'b0;
        checks++; if (held !== 4) begin failures++; $display("FAIL lh_req_stable got=%0d cycles exp=4", held); end
        checks++; if (bus.mem_req !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL lh_wait got=%b/%b exp=0/0", bus.mem_req, rsp_valid); end
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h8001_0000;
        step();
        bus.mem_rvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_rsp got=%b/%h exp=1/ffff8001", rsp_valid, rsp_data); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL lh_one_cycle got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_nonmem();
        bus.mem_gnt = 1'b1;
        issue(1'b0, 1'b0, 3'b010, 32'hDEAD_BEEF, 32'h0);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL nonmem_rsp got=%b/%h exp=1/deadbeef", rsp_valid, rsp_data); end
        checks++; if (bus.mem_req !== 1'b0 || misaligned !== 1'b0) begin failures++; $display("FAIL nonmem_noreq got=%b/%b exp=0/0", bus.mem_req, misaligned); end
        bus.mem_gnt = 1'b0;
        step();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL nonmem_idle got=%b/%b exp=0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_lw_misaligned();
        issue(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL lw_mis_noreq got=%b exp=0", bus.mem_req); end
        checks++; if (rsp_valid !== 1'b1 || misaligned !== 1'b1 || rsp_data !== 32'd0) begin failures++; $display("FAIL lw_mis_rsp got=%b/%b/%h exp=1/1/00000000", rsp_valid, misaligned, rsp_data); end
        step();
`else
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_3000 || bus.mem_be !== 4'b1111) begin failures++; $display("FAIL lw_align_bus got=%b/%h/%b exp=1/00003000/1111", bus.mem_req, bus.mem_addr, bus.mem_be); end
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        step();
        bus.mem_rvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFE_F00D || misaligned !== 1'b0) begin failures++; $display("FAIL lw_align_rsp got=%b/%h/%b exp=1/cafef00d/0", rsp_valid, rsp_data, misaligned); end
        step();
`endif
    endtask

    task automatic test_back_to_back();
        MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h0000_0011;
        req_valid = 1'b1;
        step();
        ALUResult = 32'h0000_0022;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_0011 || req_ready !== 1'b0) begin failures++; $display("FAIL b2b_first got=%b/%h/%b exp=1/00000011/0", rsp_valid, rsp_data, req_ready); end
        step();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL b2b_gap got=%b/%b exp=0/1", rsp_valid, req_ready); end
        step();
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_0022) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/00000022", rsp_valid, rsp_data); end
        step();
    endtask

    task automatic test_reset_mid();
        // Reset while requesting: mem_req must fall without waiting for a clock edge.
        issue(1'b0, 1'b1, 3'b010, 32'h0000_5000, 32'h1111_2222);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || req_ready !== 1'b1 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin failures++; $display("FAIL rst_req got=%b/%b/%h/%h exp=0/1/0/0", bus.mem_req, req_ready, bus.mem_addr, bus.mem_wdata); end
        step();
        rst_n = 1'b1;
        step();
        // Reset while waiting for load data, then a late rvalid.
        issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_wait got=%b/%b/%b exp=0/1/0", bus.mem_req, req_ready, rsp_valid); end
        step();
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
        step();
        bus.mem_rvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || req_ready !== 1'b1) begin failures++; $display("FAIL rst_late_rvalid got=%b/%h/%b exp=0/0/1", rsp_valid, rsp_data, req_ready); end
        step();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_late_rvalid2 got=%b exp=0", rsp_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
        ALUResult = 32'h0; StoreData = 32'h0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        test_reset();
        test_store_byte();
        test_store_half();
        test_load_byte(3'b000, 32'hFFFF_FFF0, "lb");
        test_load_byte(3'b100, 32'h0000_00F0, "lbu");
        test_load_half_stall();
        test_nonmem();
        test_lw_misaligned();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
